// File: rtl/minitest_shr_host.sv
// Host-side driver for the serial minitest harness: shifts a stimulus word in, strobes load/capture,
// shifts the ROI result back out. Optional macro DO_SYNC_EN adds a 2-flop synchronizer on do_i.
module minitest_shr_host #(
  parameter int DIN_N  = 256,
  parameter int DOUT_N = 256,
  parameter int SETTLE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIN_N-1:0]  in_data,
  output logic              stb,
  output logic              di,
  input  logic              do_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DOUT_N-1:0] out_data,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  localparam int MAX_A = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
  localparam int MAX_C = (MAX_A > SETTLE) ? MAX_A : SETTLE;
  localparam int CW    = $clog2(MAX_C + 1);

  // Handshakes: a word moves on any posedge where valid && ready are both high.
  // Producers hold valid and data stable until that edge; out_valid drops on it.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHIFT_IN  = 3'd1,
    S_LOAD      = 3'd2,
    S_SETTLE    = 3'd3,
    S_CAPTURE   = 3'd4,
    S_SYNC_WAIT = 3'd5,
    S_SHIFT_OUT = 3'd6
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [DIN_N-1:0]  tx, tx_n;
  logic [DOUT_N-1:0] rx, rx_n;
  logic [DOUT_N-1:0] out_data_n;
  logic              out_valid_n;
  logic              stb_n, di_n;
  logic              rx_bit;

`ifdef DO_SYNC_EN
  logic [1:0] do_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) do_sync <= '0;
    else     do_sync <= {do_sync[0], do_i};
  end

  assign rx_bit = do_sync[1];
`else
  assign rx_bit = do_i;
`endif

  assign in_ready  = (state == S_IDLE) && !out_valid;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    tx_n        = tx;
    rx_n        = rx;
    stb_n       = 1'b0;
    di_n        = 1'b0;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    if (out_valid && out_ready) out_valid_n = 1'b0;

    case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          tx_n    = in_data;
          di_n    = in_data[DIN_N-1];
          cnt_n   = CW'(DIN_N - 1);
          state_n = S_SHIFT_IN;
        end
      end
      S_SHIFT_IN: begin
        // di is registered, so the next bit is presented one edge ahead of use.
        tx_n = tx << 1;
        if (cnt == '0) begin
          stb_n   = 1'b1;
          state_n = S_LOAD;
        end else begin
          di_n  = tx_n[DIN_N-1];
          cnt_n = cnt - CW'(1);
        end
      end
      S_LOAD: begin
        cnt_n   = CW'(SETTLE - 1);
        state_n = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt == '0) begin
          stb_n   = 1'b1;
          state_n = S_CAPTURE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_CAPTURE: begin
`ifdef DO_SYNC_EN
        cnt_n   = CW'(1);
        state_n = S_SYNC_WAIT;
`else
        cnt_n   = CW'(DOUT_N - 1);
        state_n = S_SHIFT_OUT;
`endif
      end
      S_SYNC_WAIT: begin
        if (cnt == '0) begin
          cnt_n   = CW'(DOUT_N - 1);
          state_n = S_SHIFT_OUT;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_SHIFT_OUT: begin
        rx_n = (rx << 1) | DOUT_N'(rx_bit);
        if (cnt == '0) begin
          out_data_n  = rx_n;
          out_valid_n = 1'b1;
          cnt_n       = '0;
          state_n     = S_IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      tx        <= '0;
      rx        <= '0;
      stb       <= 1'b0;
      di        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      tx        <= tx_n;
      rx        <= rx_n;
      stb       <= stb_n;
      di        <= di_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
    end
  end

endmodule

// File: tb/tb_minitest_shr_host.sv
// Directed bench for minitest_shr_host with an 8-bit behavioural harness (identity or inverting roi).
module tb_minitest_shr_host;

`ifdef DO_SYNC_EN
  localparam int LAT = 24;
`else
  localparam int LAT = 22;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       stb, di, do_i;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       busy;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic invert = 1'b0;

  minitest_shr_host #(.DIN_N(8), .DOUT_N(8), .SETTLE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .stb(stb), .di(di), .do_i(do_i), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .state_dbg(state_dbg)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural harness: input shift chain, load/capture on stb, output shift chain
  logic [7:0] h_din_shr  = '0;
  logic [7:0] h_din      = '0;
  logic [7:0] h_dout_shr = '0;
  assign do_i = h_dout_shr[7];

  always @(posedge clk) begin
    h_din_shr <= {h_din_shr[6:0], di};
    if (stb) begin
      h_din      <= h_din_shr;
      h_dout_shr <= invert ? ~h_din : h_din;
    end else begin
      h_dout_shr <= {h_dout_shr[6:0], 1'b0};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: offer a word, follow it cycle by cycle from the accept edge (cycle 0)
  task automatic run_txn(input logic [7:0] data, input int abort_at, output int waited,
                         output logic [7:0] di_seq, output logic [31:0] stb_mask);
    logic [7:0] exp;
    waited   = 0;
    di_seq   = '0;
    stb_mask = '0;
    in_data  = data;
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (abort_at < 0) exp_q.push_back(invert ? ~data : data);
    check("busy_after_accept", busy, 1);
    for (int c = 0; c <= LAT; c++) begin
      if (c == abort_at) begin
        check("busy_before_abort", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_stb", stb, 0);
        check("abort_di", di, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_state", state_dbg, 0);
        return;
      end
      if (c < 8) di_seq[7-c] = di;
      stb_mask[c] = stb;
      if (c == LAT - 1) check("valid_early", out_valid, 0);
      if (c == LAT) begin
        check("valid_at_latency", out_valid, 1);
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          exp = exp_q.pop_front();
          check("out_data", out_data, exp);
        end
      end
      if (c < LAT) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    int w;
    logic [7:0] dseq;
    logic [31:0] smask;

    repeat (2) @(posedge clk);
    #1;
    check("rst_stb", stb, 0);
    check("rst_di", di, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 1);

    // loopback
    run_txn(8'hA5, -1, w, dseq, smask);
    check("loop_di_seq", dseq, 8'hA5);
    check("loop_stb_cycles", smask, 32'h0000_2100);

    // backpressure
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_txn(8'h3C, -1, w, dseq, smask);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_out_data", out_data, 8'h3C);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_hold_data", out_data, 8'h3C);

    // back-to-back
    run_txn(8'h01, -1, w, dseq, smask);
    run_txn(8'h80, -1, w, dseq, smask);
    check("b2b_accept_gap", w, 1);

    // reset during SHIFT_OUT, then recover
    run_txn(8'h5A, 17, w, dseq, smask);
    check("abort_out_data", out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_txn(8'hFF, -1, w, dseq, smask);

    // inverting roi
    @(posedge clk); #1;
    invert = 1'b1;
    run_txn(8'h00, -1, w, dseq, smask);
    check("inv_stb_cycles", smask, 32'h0000_2100);

    @(posedge clk); #1;
    check("final_idle", busy, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
